// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code front-end blocks: sampler FSM states
// and a popcount helper used to measure Hamming distance between codes.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } gray_state_t;

  // Callers zero-extend their code to 64 bits.
  function automatic int unsigned gray_weight(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// WIDTH-bit two-flop synchronizer with synchronous active-high clear.
module gray_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
    end
  end

  assign q_o = r_s2;

endmodule

// File: rtl/gray_sampler.sv
// Synchronises, samples and debounces an absolute-encoder Gray bus, publishing
// each qualified code with a one-cycle init strobe and a multi-bit-jump flag.
module gray_sampler
  import gray_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STABLE_CNT = 4,
  parameter int SAMPLE_DIV = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] gray_i,
  output logic             init_o,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o,
  output gray_state_t      state_o
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] w_sync;
  logic             w_tick;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_qualify;
  logic             w_multi;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_data;
  logic             r_init;
  logic             r_err;
  gray_state_t      r_state;

  gray_sync #(.WIDTH(WIDTH)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (gray_i),
    .q_o   (w_sync)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  assign w_tick = (r_div == DIV_MAX);

  // A saturated counter that sees the same code again must not re-qualify.
  always_comb begin
    w_same     = (w_sync == r_cand);
    w_cnt_next = CNT_ONE;
    if (w_same) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
    end
    w_qualify = w_tick && (w_cnt_next == CNT_MAX) && !(w_same && (r_cnt == CNT_MAX));
    w_multi   = (gray_weight(64'(w_sync ^ r_data)) > 32'd1);
  end

  // init_o is a valid-only strobe: no ready exists, the consumer always accepts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_init  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_init <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cand <= '0;
          r_cnt  <= '0;
          if (en_i) begin
            r_state <= ST_ACQUIRE;
          end
        end
        default: begin
          if (!en_i) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
          end else if (w_tick) begin
            r_cand <= w_sync;
            r_cnt  <= w_cnt_next;
            if (w_qualify) begin
              if (r_state == ST_ACQUIRE) begin
                r_data  <= w_sync;
                r_init  <= 1'b1;
                r_state <= ST_TRACK;
              end else if (w_sync != r_data) begin
                r_data <= w_sync;
                r_init <= 1'b1;
                r_err  <= w_multi;
              end
            end
          end
        end
      endcase
    end
  end

  assign init_o  = r_init;
  assign data_o  = r_data;
  assign err_o   = r_err;
  assign state_o = r_state;

endmodule

// File: tb/tb_gray_sampler.sv
// Bench for gray_sampler: a run-length model of the debounced publish rule is
// compared every cycle, plus directed scenarios with hand-computed results.
module tb_gray_sampler;
  import gray_pkg::*;

  localparam int W = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en;
  logic [W-1:0] gray;

  logic         init1, err1, init4, err4;
  logic [W-1:0] data1, data4;
  gray_state_t  st1, st4;

  gray_sampler #(.WIDTH(W), .STABLE_CNT(S), .SAMPLE_DIV(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .gray_i(gray),
    .init_o(init1), .data_o(data1), .err_o(err1), .state_o(st1)
  );

  gray_sampler #(.WIDTH(W), .STABLE_CNT(S), .SAMPLE_DIV(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .gray_i(gray),
    .init_o(init4), .data_o(data4), .err_o(err4), .state_o(st4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the synchronised value is the input two edges ago; while enabled
  // (and past the one idle cycle), count how many consecutive samples agree.
  logic [W-1:0] m_p0, m_p1, m_smp, m_last, m_data;
  int           m_run, m_old;
  bit           m_en_prev, m_track, m_init, m_err, m_same;

  always @(posedge clk) begin
    if (rst) begin
      m_p0 = '0; m_p1 = '0; m_last = '0; m_data = '0;
      m_run = 0; m_en_prev = 0; m_track = 0; m_init = 0; m_err = 0;
    end else begin
      m_smp = m_p1;
      m_p1  = m_p0;
      m_p0  = gray;
      m_init = 0;
      m_err  = 0;
      if (en && m_en_prev) begin
        m_old  = m_run;
        m_same = (m_run > 0) && (m_smp == m_last);
        m_run  = m_same ? ((m_run < S) ? m_run + 1 : S) : 1;
        m_last = m_smp;
        if (m_run == S && !(m_same && m_old == S) && (!m_track || m_smp != m_data)) begin
          m_init = 1;
          m_err  = m_track && ($countones(m_smp ^ m_data) > 1);
          m_data = m_smp;
          m_track = 1;
          exp_q.push_back({m_err, m_smp});
        end
      end else begin
        m_run   = 0;
        m_track = 0;
      end
      m_en_prev = en;
    end
  end

  logic [W:0] got_pub;
  always @(negedge clk) begin
    check("init_o", 32'(init1), 32'(m_init));
    check("data_o", 32'(data1), 32'(m_data));
    if (m_init) check("err_o", 32'(err1), 32'(m_err));
    if (init1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_publish", 32'(init1), 32'd0);
      end else begin
        got_pub = exp_q.pop_front();
        check("published_code", 32'({err1, data1}), 32'(got_pub));
      end
    end
  end

  int pulses1 = 0;
  bit last_err1;
  always @(posedge clk) begin
    #1;
    if (init1) begin
      pulses1++;
      last_err1 = err1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  p0, lat;
  bit  found;

  initial begin
    rst = 1'b1; en = 1'b0; gray = 4'b1111;
    cycles(2);
    check("reset_init", 32'(init1), 32'd0);
    check("reset_data", 32'(data1), 32'd0);
    check("reset_err", 32'(err1), 32'd0);
    rst = 1'b0;

    // acquire
    p0 = pulses1; en = 1'b1; gray = 4'b0110;
    cycles(60);
    check("acq_pulses", 32'(pulses1 - p0), 32'd1);
    check("acq_data", 32'(data1), 32'b0110);
    check("acq_err", 32'(last_err1), 32'd0);
    check("model_acq_data", 32'(m_data), 32'b0110);

    // glitch shorter than STABLE_CNT ticks
    p0 = pulses1; gray = 4'b0111;
    cycles(2);
    gray = 4'b0110;
    cycles(20);
    check("glitch_pulses", 32'(pulses1 - p0), 32'd0);
    check("glitch_data", 32'(data1), 32'b0110);

    // single-bit step, latency edge k+4
    p0 = pulses1; gray = 4'b0111; found = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (init1 && !found) begin
        found = 1; lat = i;
        check("step_err", 32'(err1), 32'd0);
      end
    end
    check("step_seen", 32'(found), 32'd1);
    check("step_latency", 32'(lat), 32'd5);
    check("step_pulses", 32'(pulses1 - p0), 32'd1);
    check("step_data", 32'(data1), 32'b0111);

    // multi-bit jump
    p0 = pulses1; gray = 4'b1000;
    cycles(20);
    check("jump_pulses", 32'(pulses1 - p0), 32'd1);
    check("jump_data", 32'(data1), 32'b1000);
    check("jump_err", 32'(last_err1), 32'd1);

    // enable cycle: first publish is an acquire, so no err
    en = 1'b0;
    cycles(5);
    check("hold_data_disabled", 32'(data1), 32'b1000);
    p0 = pulses1; en = 1'b1; gray = 4'b0011;
    cycles(20);
    check("reen_pulses", 32'(pulses1 - p0), 32'd1);
    check("reen_data", 32'(data1), 32'b0011);
    check("reen_err", 32'(last_err1), 32'd0);

    // prescaled instance: stable-to-strobe latency
    en = 1'b0;
    cycles(5);
    en = 1'b1; gray = 4'b0101; found = 0; lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (init4 && !found) begin
        found = 1; lat = i - 1;
        check("div4_err", 32'(err4), 32'd0);
      end
    end
    check("div4_seen", 32'(found), 32'd1);
    check("div4_latency_in_window", 32'(lat >= 2 + (S - 1) * 4 && lat <= 2 + (S - 1) * 4 + 3), 32'd1);
    check("div4_data", 32'(data4), 32'b0101);
    check("div1_data_after_div4", 32'(data1), 32'b0101);

    cycles(5);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_sampler.md
# gray_sampler

Front-end stage that captures an asynchronous Gray-coded position bus from an absolute encoder and feeds it to the Gray-to-binary converter. It synchronises the bus, samples it at a programmable rate and qualifies each new code by requiring it to be stable for several consecutive samples. It then publishes the qualified code with a one-cycle `init_o` strobe that drives the converter's `init_i` directly. Codes that differ from the previously published code in more than one bit are still published, but with `err_o` asserted.

## Interface
- `WIDTH`, 8: code width in bits; must be ≥ 1.
- `STABLE_CNT`, 4: consecutive identical samples required before a code is qualified; must be ≥ 1.
- `SAMPLE_DIV`, 16: clock cycles per sample tick; must be ≥ 1 (1 means a tick every cycle).

- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  enable; low holds the block idle.
- `gray_i`  in  WIDTH  asynchronous Gray code from pins.
- `init_o`  out  1  one-cycle strobe marking a newly published code.
- `data_o`  out  WIDTH  last published Gray code.
- `err_o`  out  1  valid only with `init_o`; the published code differs from the previous one in more than one bit.

## Operation
- **Synchronizer.** Two flops per bit, always running, cleared by reset. `sync` is the second stage.
- **Prescaler.** Counts 0 to SAMPLE_DIV-1. `tick` = (count == SAMPLE_DIV-1), and the counter wraps to 0 on tick. While `en_i` is 0, the prescaler is held at 0.
- **State machine:** IDLE, ACQUIRE, TRACK.
  - IDLE: entered on reset or whenever `en_i`=0. Candidate and stability counter are cleared.
  - IDLE → ACQUIRE: when `en_i`=1.
- **On each tick, in ACQUIRE or TRACK:**
  - If `sync` == candidate: the stability counter increments, saturating at STABLE_CNT.
  - Otherwise: candidate ← `sync` and counter ← 1.
- **Qualification.** A code qualifies when the counter's next value equals STABLE_CNT. Publication then depends on state:
  - ACQUIRE: publish unconditionally with `err_o`=0, then go to TRACK.
  - TRACK: publish only if candidate ≠ `data_o`. `err_o` = (popcount(candidate ^ `data_o`) > 1).
  - Saturated counters do not re-publish.
- **Publish action.** `data_o` ← candidate and `init_o`=1 for exactly that one cycle.
- **Output hold.** `data_o` holds between publishes and is not cleared by `en_i`=0.
- **Re-enable.** After `en_i` is deasserted and reasserted, the first publish is treated as from ACQUIRE, so `err_o`=0.
- **No backpressure.** The downstream stage always accepts.

## Timing
- **Reset values:** `init_o`=0, `data_o`=0, `err_o`=0, state IDLE, all counters and synchronizer flops 0.
- **Reset priority:** `rst_i` overrides everything, including a publish in the same cycle. Reset mid-qualification discards the candidate.
- **Latency with SAMPLE_DIV=1, in TRACK:** a `gray_i` change that is set up before edge k is loaded as candidate at edge k+2. `init_o` is then high during the cycle after edge k+1+STABLE_CNT.
- **Latency with SAMPLE_DIV>1:** add up to SAMPLE_DIV-1 cycles of tick alignment, plus (STABLE_CNT-1)·SAMPLE_DIV.
- **Glitch rejection:** any input change shorter than STABLE_CNT ticks restarts qualification and never reaches `data_o`.
- **Enable priority:** if `en_i` falls in the same cycle a publish would occur, `en_i` wins and nothing is published.
- **Strobe rate:** `init_o` pulses are separated by at least STABLE_CNT ticks.
- **Counter widths:**
  - prescaler: max(1, $clog2(SAMPLE_DIV));
  - stability counter: $clog2(STABLE_CNT+1).

## Structure
- **Shared package `gray_pkg`:**
  - `gray_state_t` enum (IDLE, ACQUIRE, TRACK);
  - `gray_weight()` popcount function, which other Gray-code blocks reuse.
- **Sub-module `gray_sync`:** a parameterised WIDTH-bit two-flop synchronizer with synchronous active-high clear.
- **Top module:** prescaler, qualifier, FSM and output registers.

## Test plan
Bench parameters: WIDTH=4, STABLE_CNT=3, SAMPLE_DIV=1.
- **Reset:** `rst_i`=1 for 2 cycles with `gray_i`=4'b1111 → `init_o`=0, `data_o`=0, `err_o`=0.
- **Acquire:** `en_i`=1, `gray_i`=4'b0110 held → exactly one `init_o` pulse, `data_o`=0110, `err_o`=0; no further pulses over 50 cycles.
- **Glitch rejection:** 0110→0111 for 2 cycles, then back to 0110 → no `init_o`; `data_o` stays 0110.
- **Valid step:** 0110→0111 held → one pulse with `data_o`=0111 and `err_o`=0, high during the cycle after edge k+4.
- **Multi-bit jump:** 0111→1000 held → one pulse with `data_o`=1000 and `err_o`=1.
- **Enable cycle and prescaler:**
  - `en_i`=0 for 5 cycles, then 1 with `gray_i`=0011 → pulse with `data_o`=0011 and `err_o`=0.
  - Repeat with SAMPLE_DIV=4 → stable-to-strobe latency lies within [2+(STABLE_CNT-1)·4, 2+(STABLE_CNT-1)·4+3].
